// File: rtl/argmax_sequencer_if.sv
// Score stream in, winning class out: valid/ready bundle
// between the neuron array, argmax_sequencer and result sink.
interface argmax_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_value;
    logic              busy;

    modport master (
        output start, flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_value, busy
    );

    modport slave (
        input  start, flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_value, busy
    );
endinterface

// File: rtl/argmax_sequencer.sv
// Serial argmax over NUM_CLASSES unsigned scores, one per beat;
// a single comparator is reused for every beat of the frame.
module argmax_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 4
) (
    input logic              clk,
    input logic              rst_n,
    argmax_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [IDX_W-1:0]  beatCnt;
    logic [IDX_W-1:0]  curIdx;
    logic [DATA_W-1:0] curMax;
    logic              accept;
    logic              lastBeat;
    logic              outFire;
    logic              clearFrame;

    assign accept   = (state == COLLECT) && bus.in_valid && !bus.flush;
    assign lastBeat = beatCnt == IDX_W'(NUM_CLASSES - 1);
    assign outFire  = (state == HOLD) && bus.out_ready;

    // A new frame opens from IDLE or on the result handshake.
    assign clearFrame = bus.start &&
                        ((state == IDLE) || outFire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (bus.start) stateNext = COLLECT;
            end
            COLLECT: begin
                if (accept && lastBeat) stateNext = HOLD;
            end
            HOLD: begin
                if (bus.out_ready)
                    stateNext = bus.start ? COLLECT : IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (bus.flush) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beatCnt <= '0;
            curIdx  <= '0;
            curMax  <= '0;
        end else if (bus.flush) begin
            beatCnt <= '0;
        end else if (clearFrame) begin
            beatCnt <= '0;
            curIdx  <= '0;
            curMax  <= '0;
        end else if (accept) begin
            beatCnt <= beatCnt + IDX_W'(1);
            // >= lets a later equal score take the win.
            if (beatCnt == '0 || bus.in_data >= curMax) begin
                curMax <= bus.in_data;
                curIdx <= beatCnt;
            end
        end
    end

    assign bus.in_ready  = state == COLLECT;
    assign bus.out_valid = state == HOLD;
    assign bus.busy      = state != IDLE;
    assign bus.out_index = curIdx;
    assign bus.out_value = curMax;
endmodule

// File: tb/tb_argmax_sequencer.sv
// Directed and random-gap checks of the serial argmax controller.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_argmax_sequencer;
    localparam int N  = 10;
    localparam int DW = 8;
    localparam int IW = 4;

    typedef logic [DW-1:0] frame_t [N];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passCnt = 0;
    int   totalCnt = 0;

    always #5 clk = ~clk;

    argmax_sequencer_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    argmax_sequencer #(
        .NUM_CLASSES(N),
        .DATA_W(DW),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int refIdx(input frame_t s);
        int best = 0;
        for (int i = 1; i < N; i++)
            if (s[i] >= s[best]) best = i;
        return best;
    endfunction

    task automatic openFrame(output int cyc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic streamBeats(input frame_t s, input int gapMax,
                               input int startAt, inout int cyc);
        for (int i = 0; i < N; i++) begin
            int gaps = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
            repeat (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                tick();
                cyc++;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            if (i == startAt) bus.start = 1'b1;
            tick();
            cyc++;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(inout int cyc, output bit timedOut);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            cyc++;
            n++;
        end
        timedOut = !bus.out_valid;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        totalCnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0)
            $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b want 000",
                     bus.in_ready, bus.out_valid, bus.busy);
        else passCnt++;
        totalCnt++;
        if (bus.out_index !== 4'd0 || bus.out_value !== 8'd0)
            $display("FAIL reset_out: idx=%0d val=%0d want 0/0",
                     bus.out_index, bus.out_value);
        else passCnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        frame_t s = '{3, 9, 1, 7, 9, 2, 0, 5, 4, 8};
        int cyc;
        bit to;
        openFrame(cyc);
        totalCnt++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL basic_open: rdy=%b busy=%b want 1/1",
                     bus.in_ready, bus.busy);
        else passCnt++;
        streamBeats(s, 0, -1, cyc);
        waitResult(cyc, to);
        totalCnt++;
        if (to || cyc != 11)
            $display("FAIL basic_latency: got %0d cycles want 11", cyc);
        else passCnt++;
        totalCnt++;
        if (bus.out_index !== 4'd4 || bus.out_value !== 8'd9)
            $display("FAIL basic_result: idx=%0d val=%0d want 4/9",
                     bus.out_index, bus.out_value);
        else passCnt++;
        totalCnt++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL basic_hold: rdy=%b busy=%b want 0/1",
                     bus.in_ready, bus.busy);
        else passCnt++;
        consume();
        totalCnt++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL basic_idle: vld=%b busy=%b want 0/0",
                     bus.out_valid, bus.busy);
        else passCnt++;
    endtask

    task automatic test_boundary();
        frame_t s [3];
        int wantIdx [3] = '{9, 9, 0};
        int wantVal [3] = '{0, 255, 200};
        int cyc;
        bit to;
        for (int i = 0; i < N; i++) begin
            s[0][i] = 8'h00;
            s[1][i] = 8'hFF;
            s[2][i] = 8'h00;
        end
        s[2][0] = 8'd200;
        for (int f = 0; f < 3; f++) begin
            openFrame(cyc);
            streamBeats(s[f], 0, -1, cyc);
            waitResult(cyc, to);
            totalCnt++;
            if (to || bus.out_index !== IW'(wantIdx[f]) ||
                bus.out_value !== DW'(wantVal[f]))
                $display("FAIL boundary%0d: idx=%0d val=%0d want %0d/%0d",
                         f, bus.out_index, bus.out_value,
                         wantIdx[f], wantVal[f]);
            else passCnt++;
            consume();
        end
    endtask

    task automatic test_stall_random();
        frame_t s = '{10, 40, 40, 5, 30, 1, 2, 3, 4, 6};
        int cyc;
        bit to;
        openFrame(cyc);
        streamBeats(s, 3, -1, cyc);
        waitResult(cyc, to);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hFF;
            tick();
            totalCnt++;
            if (to || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_index !== 4'd2 || bus.out_value !== 8'd40)
                $display("FAIL stall%0d: vld=%b rdy=%b idx=%0d val=%0d want 1/0/2/40",
                         k, bus.out_valid, bus.in_ready,
                         bus.out_index, bus.out_value);
            else passCnt++;
        end
        bus.in_valid = 1'b0;
        consume();
        for (int f = 0; f < 100; f++) begin
            frame_t r;
            int wi;
            for (int i = 0; i < N; i++)
                r[i] = (f % 2 == 0) ? DW'($urandom_range(0, 7))
                                    : DW'($urandom_range(0, 255));
            wi = refIdx(r);
            openFrame(cyc);
            streamBeats(r, 2, -1, cyc);
            waitResult(cyc, to);
            totalCnt++;
            if (to || bus.out_index !== IW'(wi) || bus.out_value !== r[wi])
                $display("FAIL rand%0d: idx=%0d val=%0d want %0d/%0d",
                         f, bus.out_index, bus.out_value, wi, r[wi]);
            else passCnt++;
            consume();
        end
    endtask

    task automatic test_back_to_back();
        frame_t a = '{1, 2, 250, 3, 4, 5, 6, 7, 8, 9};
        frame_t b = '{1, 2, 3, 4, 5, 6, 9, 10, 7, 8};
        int cyc;
        bit to;
        openFrame(cyc);
        streamBeats(a, 0, -1, cyc);
        waitResult(cyc, to);
        totalCnt++;
        if (to || bus.out_index !== 4'd2 || bus.out_value !== 8'd250)
            $display("FAIL b2b_first: idx=%0d val=%0d want 2/250",
                     bus.out_index, bus.out_value);
        else passCnt++;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        totalCnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL b2b_reopen: rdy=%b vld=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        else passCnt++;
        cyc = 1;
        streamBeats(b, 0, -1, cyc);
        waitResult(cyc, to);
        totalCnt++;
        if (to || bus.out_index !== 4'd7 || bus.out_value !== 8'd10)
            $display("FAIL b2b_second: idx=%0d val=%0d want 7/10",
                     bus.out_index, bus.out_value);
        else passCnt++;
        consume();
    endtask

    task automatic test_flush();
        frame_t s = '{1, 1, 1, 50, 1, 1, 1, 1, 1, 1};
        int cyc;
        bit to;
        openFrame(cyc);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(100 + i);
            tick();
        end
        bus.in_data = 8'd255;
        bus.flush   = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        totalCnt++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_valid !== 1'b0)
            $display("FAIL flush_idle: rdy=%b busy=%b vld=%b want 0/0/0",
                     bus.in_ready, bus.busy, bus.out_valid);
        else passCnt++;
        openFrame(cyc);
        streamBeats(s, 0, -1, cyc);
        waitResult(cyc, to);
        totalCnt++;
        if (to || cyc != 11 || bus.out_index !== 4'd3 ||
            bus.out_value !== 8'd50)
            $display("FAIL flush_next: cyc=%0d idx=%0d val=%0d want 11/3/50",
                     cyc, bus.out_index, bus.out_value);
        else passCnt++;
        consume();
    endtask

    task automatic test_async_reset();
        frame_t s = '{5, 6, 7, 80, 2, 3, 4, 1, 0, 9};
        int cyc;
        bit to;
        openFrame(cyc);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(60 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        totalCnt++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.out_index !== 4'd0 || bus.out_value !== 8'd0)
            $display("FAIL arst_collect: busy=%b rdy=%b idx=%0d val=%0d want 0/0/0/0",
                     bus.busy, bus.in_ready, bus.out_index, bus.out_value);
        else passCnt++;
        #2 rst_n = 1'b1;
        tick();
        openFrame(cyc);
        streamBeats(s, 0, -1, cyc);
        waitResult(cyc, to);
        #3 rst_n = 1'b0;
        #1;
        totalCnt++;
        if (to || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_index !== 4'd0 || bus.out_value !== 8'd0)
            $display("FAIL arst_hold: vld=%b busy=%b idx=%0d val=%0d want 0/0/0/0",
                     bus.out_valid, bus.busy, bus.out_index, bus.out_value);
        else passCnt++;
        #2 rst_n = 1'b1;
        tick();
        openFrame(cyc);
        streamBeats(s, 0, 4, cyc);
        totalCnt++;
        if (bus.out_valid !== 1'b1 || cyc != 11)
            $display("FAIL spurious_start: vld=%b cyc=%0d want 1/11",
                     bus.out_valid, cyc);
        else passCnt++;
        totalCnt++;
        if (bus.out_index !== 4'd3 || bus.out_value !== 8'd80)
            $display("FAIL spurious_result: idx=%0d val=%0d want 3/80",
                     bus.out_index, bus.out_value);
        else passCnt++;
        consume();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_stall_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
